// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and limits for the round-robin Wishbone arbiter.
// Index width helper keeps the picker and the top level in agreement.
package wb_rr_arbiter_pkg;

  localparam int MAX_MASTERS = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first requester searching upward from last+1.
// Zero latency; no backpressure, the caller samples the result when it can grant.
module wb_rr_picker
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid
);

  // cand[0] is the highest-priority index, cand[NUM_MASTERS-1] is last itself
  logic [IDX_W-1:0] cand [NUM_MASTERS];

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand[i] = IDX_W'((int'(last) + i + 1) % NUM_MASTERS);
    end
  end

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!valid && req[cand[i]]) begin
        valid          = 1'b1;
        idx            = cand[i];
        gnt[cand[i]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter; grant held for the whole CYC, one idle turnaround cycle.
// Grant one cycle after CYC is sampled; stalled strobes are ended by a watchdog ERR to the owner.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  output logic [NUM_MASTERS-1:0]            gnt_o,
  output logic                              timeout_o
);

  localparam int IDX_W = idx_width(NUM_MASTERS);
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_num_masters
    $error("wb_rr_arbiter: NUM_MASTERS out of range");
  end

  arb_state_t             state, state_nxt;
  logic [NUM_MASTERS-1:0] gnt_nxt;
  logic [IDX_W-1:0]       own, own_nxt;
  logic [IDX_W-1:0]       last, last_nxt;
  logic [WD_W-1:0]        wd_cnt;
  logic                   busy, wd_fire, wd_clr;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_vld;

  wb_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req  (m_cyc_i),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .valid(pick_vld)
  );

  assign busy    = (state == ARB_BUSY);
  assign wd_fire = (TIMEOUT_CYCLES != 0) && busy && (wd_cnt == WD_MAX);
  assign m_dat_o = s_dat_i;

  // Everything toward the slave and back is gated by busy, so reset silences it combinationally
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (busy) begin
      s_cyc_o      = m_cyc_i[own];
      s_stb_o      = m_stb_i[own] & ~wd_fire;
      s_we_o       = m_we_i[own];
      s_adr_o      = m_adr_i[int'(own)*ADDR_WIDTH +: ADDR_WIDTH];
      s_dat_o      = m_dat_i[int'(own)*DATA_WIDTH +: DATA_WIDTH];
      m_ack_o[own] = s_ack_i & ~wd_fire;
      m_err_o[own] = s_err_i | wd_fire;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_o;
    own_nxt   = own;
    last_nxt  = last;
    case (state)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_nxt = ARB_BUSY;
          gnt_nxt   = pick_gnt;
          own_nxt   = pick_idx;
        end
      end
      ARB_BUSY: begin
        // Release always passes through IDLE, giving the slave a turnaround cycle
        if (!m_cyc_i[own]) begin
          state_nxt = ARB_IDLE;
          gnt_nxt   = '0;
          last_nxt  = own;
        end
      end
    endcase
  end

  // A firing watchdog masks s_stb_o, so the count also clears on the cycle after it fires
  assign wd_clr = (TIMEOUT_CYCLES == 0) || (state_nxt != ARB_BUSY) ||
                  !s_stb_o || s_ack_i || s_err_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ARB_IDLE;
      gnt_o     <= '0;
      own       <= '0;
      last      <= IDX_W'(NUM_MASTERS - 1);
      wd_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt_o     <= gnt_nxt;
      own       <= own_nxt;
      last      <= last_nxt;
      wd_cnt    <= wd_clr ? '0 : wd_cnt + 1'b1;
      timeout_o <= wd_fire;
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Shares one Wishbone B4 classic slave port between NUM_MASTERS requesters, for example several sequential memory-access masters in front of one RAM.
- Uses round-robin arbitration on CYC.
- A grant is held for the full CYC assertion, so a master can lock the bus across back-to-back SINGLE WRITE and SINGLE READ cycles.
- A watchdog terminates stalled cycles with an ERR to the owning master.

Parameters:
- NUM_MASTERS, 4, number of requesting masters; legal range 2..8.
- ADDR_WIDTH, 16, address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 255, number of STB-high cycles without ACK/ERR before a watchdog ERR; 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- m_cyc_i  in  NUM_MASTERS  per-master CYC.
- m_stb_i  in  NUM_MASTERS  per-master STB.
- m_we_i  in  NUM_MASTERS  per-master WE.
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data, packed the same way.
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master ACK.
- m_err_o  out  NUM_MASTERS  per-master ERR.
- s_cyc_o, s_stb_o, s_we_o  out  1  to slave.
- s_adr_o  out  ADDR_WIDTH  to slave.
- s_dat_o  out  DATA_WIDTH  to slave.
- s_dat_i  in  DATA_WIDTH  from slave.
- s_ack_i, s_err_i  in  1  from slave.
- gnt_o  out  NUM_MASTERS  registered one-hot grant, all-zero when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset state (asynchronous):
  - state=IDLE, gnt_o=0, last pointer=NUM_MASTERS-1 (so master 0 has first priority), watchdog count=0, timeout_o=0.
  - All s_* strobes and all m_ack_o/m_err_o are low immediately, combinationally from gnt_o=0.
  - Reset mid-cycle drops s_cyc_o at once; the slave must tolerate the abort.
- States: IDLE and BUSY.
- IDLE:
  - If any m_cyc_i is high, the picker selects the first requester searching upward from last+1 modulo NUM_MASTERS.
  - The grant is registered and state goes to BUSY.
  - Latency: m_cyc_i rising at edge N gives gnt_o and s_cyc_o high after edge N+1.
- BUSY:
  - Slave outputs are combinational from the owner: s_cyc_o=m_cyc_i[own]; s_stb_o=m_stb_i[own]&~wd_fire; s_we_o/s_adr_o/s_dat_o from slice own.
  - m_dat_o=s_dat_i at all times.
  - m_ack_o[own]=s_ack_i.
  - m_err_o[own]=s_err_i|wd_fire.
  - Non-owners see ACK=ERR=0 and must wait.
  - When m_cyc_i[own] samples low: state goes to IDLE, gnt_o is cleared, last=own.
  - There is exactly one idle cycle before the next grant (bus turnaround), even when other masters are waiting.
- Fairness: with all masters requesting continuously and each holding CYC for one transfer, grants rotate 0,1,2,3,0… and no master waits more than NUM_MASTERS-1 tenures.
- Watchdog:
  - Counter width is clog2(TIMEOUT_CYCLES+1).
  - Increments on each edge where BUSY & s_stb_o & ~s_ack_i & ~s_err_i.
  - Clears on ACK/ERR, on STB low, and on leaving BUSY.
  - wd_fire is combinational (count==TIMEOUT_CYCLES). While it is high, it masks s_stb_o and asserts ERR to the owner for that cycle.
  - timeout_o is the registered version of wd_fire. The counter then clears.
  - The grant is kept; the owner decides whether to retry or drop CYC.
- Simultaneous events:
  - If slave ACK and wd_fire coincide, wd_fire wins: m_ack_o is masked and ERR is delivered.
  - If the owner drops CYC while another master raises CYC on the same edge, the owner is released first and the new master arbitrates from IDLE.
  - If a master raises and lowers CYC while not granted, nothing happens.
- gnt_o is always one-hot or zero; violating this is an assertion failure.

Decomposition:
- Package wb_rr_arbiter_pkg contains:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY}.
  - Constant MAX_MASTERS=8.
- Sub-module wb_rr_picker: purely combinational round-robin priority encoder.
  - Inputs: req vector, last index.
  - Outputs: one-hot gnt, index, valid.
- The top level holds the FSM, watchdog and muxes.

Test Plan:
- Single requester: master 2 raises CYC/STB/WE with adr=0x0005, dat=0x0000000A; slave ACKs 2 cycles later. Expected: gnt_o=0b0100 one cycle after CYC, s_adr_o=0x0005, m_ack_o=0b0100 for one cycle, gnt_o=0 one cycle after CYC drops.
- All 4 masters hold CYC continuously, each doing one transfer per tenure from reset. Expected: grant order 0,1,2,3,0,1 with exactly one idle cycle between tenures.
- Locked tenure: master 1 does a write (ACK), drops STB for one cycle, then does a read (slave returns 0x12345678) while master 0 requests throughout. Expected: gnt_o stays 0b0010 across both transfers, master 1 sees dat 0x12345678, master 0 is granted only after master 1 drops CYC.
- Watchdog: TIMEOUT_CYCLES=4, master 0 strobes and the slave never ACKs. Expected: m_err_o[0] pulses at the 5th STB cycle, s_stb_o is low that cycle, timeout_o pulses the next cycle, grant is retained.
- ACK and timeout coincide at the same edge. Expected: m_err_o=1, m_ack_o=0.
- Reset asserted mid-transfer while master 3 is granted with STB high. Expected: s_cyc_o/s_stb_o/gnt_o go low without a clock edge; after release, master 0 wins if all masters request.
